// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [N-1:0] wd,
  input  logic         abort,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count;
  logic [2*N:0]   acc, acc_step;
  logic [N-1:0]   opd, orig_a;
  logic           is_div, neg_q, neg_r, b_zero;

  logic [N-1:0]   a_abs, b_abs;
  logic [N:0]     mul_sum;
  logic [N+1:0]   diff;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   q_fix, r_fix;

  assign a_abs = (op[0] && inA[N-1]) ? -inA : inA;
  assign b_abs = (op[0] && inB[N-1]) ? -inB : inB;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !abort) state_d = RUN;
      RUN: begin
        if (abort)                        state_d = IDLE;
        else if (count == CW'(N - 1))     state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // opd holds the multiplicand or the divisor; acc starts with the other operand in its low half
  always_comb begin
    mul_sum  = acc[2*N:N] + {1'b0, opd};
    diff     = {1'b0, acc[2*N-1:N-1]} - {2'b00, opd};
    acc_step = acc;
    if (is_div) begin
      if (!diff[N+1]) acc_step = {diff[N:0], acc[N-2:0], 1'b1};
      else            acc_step = {acc[2*N-1:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {1'b0, mul_sum, acc[N-1:1]};
      else        acc_step = {1'b0, acc[2*N:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc[2*N-1:0] : acc[2*N-1:0];
    q_fix    = neg_q ? -acc[N-1:0]   : acc[N-1:0];
    r_fix    = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      acc         <= '0;
      opd         <= '0;
      orig_a      <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!abort) begin
              count  <= '0;
              is_div <= op[1];
              neg_q  <= op[0] & (inA[N-1] ^ inB[N-1]);
              neg_r  <= op[0] & inA[N-1];
              b_zero <= (inB == '0);
              orig_a <= inA;
              opd    <= op[1] ? b_abs : a_abs;
              acc    <= {{(N+1){1'b0}}, (op[1] ? a_abs : b_abs)};
            end
          end else begin
            if (mthi) hi <= wd;
            if (mtlo) lo <= wd;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        FIX: begin
          if (!abort) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*N-1:N];
              lo <= prod_fix[N-1:0];
            end else if (b_zero) begin
              hi          <= orig_a;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized model-checked bench for mult_div_unit
module tb_mult_div_unit;
  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, mthi = 1'b0, mtlo = 1'b0, abort = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] inA = '0, inB = '0, wd = '0;
  logic [N-1:0] hi, lo;
  logic         busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .mthi(mthi), .mtlo(mtlo), .wd(wd), .abort(abort),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // architectural result of one operation, straight from the arithmetic definition
  task automatic compute(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output bit dz);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = ua * ub; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (b == 0) begin
          rh = a; rl = '1; dz = 1'b1;
        end else if (o == 2'b10) begin
          rl = a / b; rh = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          rl = q[31:0]; rh = r[31:0];
        end
      end
    endcase
  endtask

  // model: pending result lands N+1 edges after the accepting edge
  int          rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_done = 0, m_dbz = 0, p_dbz = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem = 0; m_hi = '0; m_lo = '0; m_done = 0; m_dbz = 0;
    end else begin
      m_done = 0;
      m_dbz  = 0;
      if (rem > 0) begin
        if (abort) rem = 0;
        else begin
          rem--;
          if (rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dbz = p_dbz;
          end
        end
      end else if (start) begin
        if (!abort) begin
          compute(op, inA, inB, p_hi, p_lo, p_dbz);
          rem = N + 1;
        end
      end else begin
        if (mthi) m_hi = wd;
        if (mtlo) m_lo = wd;
      end
    end
  end

  always @(negedge clock) begin
    chk("busy", busy, rem > 0);
    chk("done", done, m_done);
    chk("div_by_zero", div_by_zero, m_dbz);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, output int lat);
    if (!b2b) @(negedge clock);
    op = o; inA = a; inB = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    chk("op_timeout", lat < 60, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0001;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op(input bit b2b);
    int ab;
    if (!b2b) @(negedge clock);
    op = 2'($urandom_range(0, 3)); inA = pick(); inB = pick();
    start = 1'b1;
    abort = ($urandom_range(0, 15) == 0);
    ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, N + 1) : 0;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c < 40 && busy; c++) begin
      start = ($urandom_range(0, 7) == 0);
      mthi  = ($urandom_range(0, 7) == 0);
      mtlo  = ($urandom_range(0, 7) == 0);
      wd    = $urandom;
      inA   = $urandom;
      abort = (c == ab);
      @(negedge clock);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0; abort = 1'b0;
    end
    chk("rand_timeout", busy, 0);
  endtask

  initial begin
    int lat, dones;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    chk("multu_lat", lat, 33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1, lat);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, lat);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, lat);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    chk("div_ovf_dz", div_by_zero, 0);
    run_op(2'b10, 32'd5, 32'd0, 0, lat);
    chk("dz_hi", hi, 32'd5);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_flag", div_by_zero, 1);

    @(negedge clock); wd = 32'h1234; mtlo = 1'b1;
    @(negedge clock); mtlo = 1'b0;
    chk("mtlo", lo, 32'h1234);

    @(negedge clock); op = 2'b01; inA = 32'd3; inB = 32'd4; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1; mthi = 1'b1; wd = 32'hDEAD; inA = 32'd100;
    @(negedge clock); start = 1'b0; mthi = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin @(negedge clock); lat++; end
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd12);
    @(negedge clock);
    chk("ign_busy", busy, 0);

    @(negedge clock); wd = 32'hAAAA_0000; mthi = 1'b1;
    @(negedge clock); mthi = 1'b0; wd = 32'h5555; mtlo = 1'b1;
    @(negedge clock); mtlo = 1'b0; op = 2'b00; inA = 32'd9; inB = 32'd9; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (9) @(negedge clock);
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 32'hAAAA_0000);
    chk("abort_lo", lo, 32'h5555);
    dones = 0;
    repeat (40) begin @(negedge clock); dones += done; end
    chk("abort_nodone", dones, 0);

    @(negedge clock); op = 2'b11; inA = 32'd77; inB = 32'd5; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clock); reset = 1'b1;
    dones = 0;
    repeat (40) begin @(negedge clock); dones += done; end
    chk("rst_nodone", dones, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clock);
        wd = $urandom; mthi = $urandom_range(0, 1); mtlo = $urandom_range(0, 1);
        abort = $urandom_range(0, 1);
        @(negedge clock); mthi = 1'b0; mtlo = 1'b0; abort = 1'b0;
      end else begin
        rand_op($urandom_range(0, 1));
      end
    end
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
